cnn_fmap_buffer: RTL and testbench
==================================

Name: cnn_fmap_buffer

Overview:
- Successor to the single-frame conv result collector. Sits after cnn_core and captures one full CO-channel output frame, OUT_W x OUT_H, from the core's valid/fmap stream.
- Each result is requantized before storage: optional ReLU, arithmetic right shift, signed saturation to O_BW.
- The stored frame is then streamed out over a ready/valid read port, channel-major, toward the next layer.
- Adds what the old collector lacked: start/busy/done control, runtime quantization, readback, and overrun detection.

Parameters:
- CO, 3, output channel count.
- I_BW, 23, signed width of each input channel word.
- O_BW, 8, signed width of each stored/output word.
- OUT_W, 24, frame width.
- OUT_H, 24, frame height.
- SHIFT_BW, 5, width of the shift amount.
- Derived localparams: CH_BW=$clog2(CO) (min 1), X_BW=$clog2(OUT_W), Y_BW=$clog2(OUT_H).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  arms capture of one frame; samples i_shift and i_relu_en.
- i_shift  in  SHIFT_BW  arithmetic right-shift amount.
- i_relu_en  in  1  1 = clamp negatives to 0 before shifting.
- i_valid  in  1  input beat valid (no back-pressure).
- i_fmap  in  CO*I_BW  channel c in bits [c*I_BW +: I_BW].
- o_busy  out  1  high in CAPTURE and READOUT.
- o_frame_done  out  1  one-cycle pulse when the last read beat is accepted.
- o_err_overrun  out  1  sticky input-drop flag.
- o_rd_valid  out  1  read beat valid.
- i_rd_ready  in  1  read beat accepted when o_rd_valid && i_rd_ready.
- o_rd_data  out  O_BW  quantized value.
- o_rd_ch  out  CH_BW  channel of the beat.
- o_rd_x  out  X_BW  x coordinate of the beat.
- o_rd_y  out  Y_BW  y coordinate of the beat.
- o_rd_last  out  1  marks the final beat (ch=CO-1, y=OUT_H-1, x=OUT_W-1).

Behaviour:
- Reset: state IDLE, all counters 0, latched shift/relu 0, and every output 0. Memory contents are don't-care.
- Reset asserted mid-frame aborts the frame; no o_frame_done is produced.
- FSM IDLE: i_start moves to CAPTURE, latches shift/relu, clears o_err_overrun, and zeroes x/y counters.
- i_start outside IDLE is ignored.
- CAPTURE, per i_valid beat:
  - All CO channels are written at address (y,x) in the same cycle.
  - x increments; at OUT_W-1, x wraps to 0 and y increments.
  - The beat at (OUT_W-1, OUT_H-1) moves the FSM to READOUT on the next cycle.
- i_valid while IDLE or READOUT: the beat is dropped and o_err_overrun sets, taking effect the next cycle. It stays set until the next accepted i_start.
- READOUT order: ch outer, y middle, x inner. Total CO*OUT_W*OUT_H beats.
  - Memory read is synchronous.
  - If the last capture beat is in cycle N, the first o_rd_valid is high in cycle N+2.
  - Sustained throughput is 1 beat/cycle while i_rd_ready=1. Use a prefetch/skid register as needed.
- Read handshake:
  - While o_rd_valid && !i_rd_ready, all o_rd_* outputs hold stable.
  - o_rd_valid never drops without acceptance.
- On acceptance of the o_rd_last beat: o_frame_done pulses in the next cycle, the FSM returns to IDLE, and o_busy falls in that same cycle.
- If i_start is asserted in the same cycle o_frame_done pulses, it is accepted (state is IDLE).
- Quantization, per channel, combinational before the write:
  - v = signed input.
  - If relu, v = max(v, 0).
  - v = v >>> shift (floor).
  - Saturate to [-2^(O_BW-1), 2^(O_BW-1)-1].
  - shift >= I_BW yields 0 or -1.

Decomposition:
- Shared package cnn_pkg: O_BW default and a saturating-shift function usable by later layers.
- One sub-module, cnn_requant: the combinational ReLU/shift/saturate for one channel, instantiated CO times.
- Storage is an inferred array [CO*OUT_H*OUT_W] with a single write port of CO lanes. Implement as CO banks.

Test Plan:
- CO=2, OUT_W=4, OUT_H=3, shift=0, relu=0; feed 12 beats of ch0=k, ch1=-k → 24 read beats with ready=1, beat i carries ch=i/12, y=(i%12)/4, x=i%4. o_rd_last only on beat 23, o_frame_done pulse one cycle later, first o_rd_valid 2 cycles after the last input.
- I_BW=23, O_BW=8, shift=4: inputs 1000, -1000 (relu=0), -1000 (relu=1), 5000, -5000 (relu=0) → stored 62, -63, 0, 127, -128.
- Random i_rd_ready with 50% stalls → data and coordinates are held during every stall, none lost or duplicated, 24 beats total.
- i_valid pulse in IDLE and one during READOUT → o_err_overrun=1 and stays set, readout data is unaffected. Next i_start clears it.
- reset after 5 capture beats, then i_start plus a full frame → clean restart at (0,0), correct readout, exactly one o_frame_done.
- i_start coincident with o_frame_done → the new capture is armed, o_busy is high the following cycle.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN layer types, defaults and the requantization helper
package cnn_pkg;

    localparam int DEF_O_BW = 8;

    typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} fmap_state_e;

    // optional ReLU, floor right shift, then clamp to a signed obw-bit range
    function automatic logic signed [47:0] sat_shift(
        input logic signed [47:0] v,
        input logic [7:0]         sh,
        input logic               relu,
        input int                 obw
    );
        logic signed [47:0] t;
        logic signed [47:0] hi;
        logic signed [47:0] lo;
        t  = (relu && v < 0) ? '0 : v;
        t  = t >>> sh;
        hi = (48'sd1 <<< (obw - 1)) - 48'sd1;
        lo = ~hi;
        return t > hi ? hi : t < lo ? lo : t;
    endfunction

endpackage

// File: rtl/cnn_requant.sv
// cnn_requant: combinational ReLU/shift/saturate of one channel word
module cnn_requant
    import cnn_pkg::*;
#(
    parameter int I_BW     = 23,
    parameter int O_BW     = DEF_O_BW,
    parameter int SHIFT_BW = 5
) (
    input  logic signed [I_BW-1:0]     i_v,
    input  logic        [SHIFT_BW-1:0] i_shift,
    input  logic                       i_relu,
    output logic        [O_BW-1:0]     o_q
);

    assign o_q = O_BW'(sat_shift(48'(i_v), 8'(i_shift), i_relu, O_BW));

endmodule

// File: rtl/cnn_fmap_buffer.sv
// cnn_fmap_buffer: captures one requantized CO-channel frame and streams it out channel-major
module cnn_fmap_buffer
    import cnn_pkg::*;
#(
    parameter int CO       = 3,
    parameter int I_BW     = 23,
    parameter int O_BW     = DEF_O_BW,
    parameter int OUT_W    = 24,
    parameter int OUT_H    = 24,
    parameter int SHIFT_BW = 5,
    localparam int CH_BW   = CO > 1 ? $clog2(CO) : 1,
    localparam int X_BW    = $clog2(OUT_W),
    localparam int Y_BW    = $clog2(OUT_H)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic [SHIFT_BW-1:0]    i_shift,
    input  logic                   i_relu_en,
    input  logic                   i_valid,
    input  logic [CO*I_BW-1:0]     i_fmap,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_err_overrun,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    output logic [O_BW-1:0]        o_rd_data,
    output logic [CH_BW-1:0]       o_rd_ch,
    output logic [X_BW-1:0]        o_rd_x,
    output logic [Y_BW-1:0]        o_rd_y,
    output logic                   o_rd_last
);

    localparam int DEPTH = OUT_W * OUT_H;
    localparam int A_BW  = $clog2(DEPTH);
    localparam int NB    = 2 ** CH_BW;

    fmap_state_e       state_q, state_d;
    logic [X_BW-1:0]   x_q, x_d, rx_q, rx_d, ox_q, ox_d;
    logic [Y_BW-1:0]   y_q, y_d, ry_q, ry_d, oy_q, oy_d;
    logic [CH_BW-1:0]  rch_q, rch_d, och_q, och_d;
    logic [SHIFT_BW-1:0] shift_q, shift_d;
    logic relu_q, relu_d, ovr_q, ovr_d, iss_q, iss_d, vld_q, vld_d;
    logic last_q, last_d, done_q, done_d;
    logic wr, ld, adv, xw, cap_last, rxw, ryw, rlast;
    logic [A_BW-1:0]     waddr, raddr;
    logic [CO*O_BW-1:0]  q_all;
    logic [NB*O_BW-1:0]  rd_all;

    assign waddr = A_BW'(y_q) * A_BW'(OUT_W) + A_BW'(x_q);
    assign raddr = A_BW'(ry_q) * A_BW'(OUT_W) + A_BW'(rx_q);

    // one bank per channel; the registered read port doubles as the output data register
    for (genvar c = 0; c < NB; c++) begin : g_bank
        if (c < CO) begin : g_live
            logic [O_BW-1:0] mem [DEPTH];
            logic [O_BW-1:0] rd_q;
            cnn_requant #(.I_BW(I_BW), .O_BW(O_BW), .SHIFT_BW(SHIFT_BW)) u_rq (
                .i_v    (i_fmap[c*I_BW +: I_BW]),
                .i_shift(shift_q),
                .i_relu (relu_q),
                .o_q    (q_all[c*O_BW +: O_BW])
            );
            // all channel lanes are written at the same (y,x) address
            always_ff @(posedge clk) begin
                if (wr) mem[waddr] <= q_all[c*O_BW +: O_BW];
            end
            // read only advances when the output slot is free or being drained
            always_ff @(posedge clk) begin
                if (reset) rd_q <= '0;
                else if (ld) rd_q <= mem[raddr];
            end
            assign rd_all[c*O_BW +: O_BW] = rd_q;
        end else begin : g_pad
            assign rd_all[c*O_BW +: O_BW] = '0;
        end
    end

    // next-state: capture counters, readout issue counters and output beat register
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        shift_d  = shift_q;
        relu_d   = relu_q;
        rch_d    = rch_q;
        ry_d     = ry_q;
        rx_d     = rx_q;
        iss_d    = iss_q;
        vld_d    = vld_q;
        och_d    = och_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        last_d   = last_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q | (i_valid && state_q != CAPTURE);
        xw       = x_q == X_BW'(OUT_W - 1);
        cap_last = xw && y_q == Y_BW'(OUT_H - 1);
        rxw      = rx_q == X_BW'(OUT_W - 1);
        ryw      = ry_q == Y_BW'(OUT_H - 1);
        rlast    = rxw && ryw && rch_q == CH_BW'(CO - 1);
        wr       = state_q == CAPTURE && i_valid;
        adv      = !vld_q || i_rd_ready;
        ld       = state_q == READOUT && adv && !iss_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = CAPTURE;
                    shift_d = i_shift;
                    relu_d  = i_relu_en;
                    ovr_d   = i_valid;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            CAPTURE: begin
                if (i_valid) begin
                    x_d = xw ? '0 : x_q + 1'b1;
                    y_d = cap_last ? '0 : xw ? y_q + 1'b1 : y_q;
                    if (cap_last) begin
                        state_d = READOUT;
                        rch_d   = '0;
                        ry_d    = '0;
                        rx_d    = '0;
                        iss_d   = 1'b0;
                    end
                end
            end
            READOUT: begin
                if (adv) vld_d = !iss_q;
                if (ld) begin
                    och_d  = rch_q;
                    oy_d   = ry_q;
                    ox_d   = rx_q;
                    last_d = rlast;
                    iss_d  = rlast;
                    rx_d   = rxw ? '0 : rx_q + 1'b1;
                    ry_d   = rxw ? (ryw ? '0 : ry_q + 1'b1) : ry_q;
                    rch_d  = (rxw && ryw) ? rch_q + 1'b1 : rch_q;
                end
                if (vld_q && i_rd_ready && last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            rch_q   <= '0;
            ry_q    <= '0;
            rx_q    <= '0;
            iss_q   <= 1'b0;
            vld_q   <= 1'b0;
            och_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            rch_q   <= rch_d;
            ry_q    <= ry_d;
            rx_q    <= rx_d;
            iss_q   <= iss_d;
            vld_q   <= vld_d;
            och_q   <= och_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_busy        = state_q != IDLE;
    assign o_frame_done  = done_q;
    assign o_err_overrun = ovr_q;
    assign o_rd_valid    = vld_q;
    assign o_rd_data     = rd_all[och_q*O_BW +: O_BW];
    assign o_rd_ch       = och_q;
    assign o_rd_x        = ox_q;
    assign o_rd_y        = oy_q;
    assign o_rd_last     = last_q;

endmodule

// File: tb/tb_cnn_fmap_buffer.sv
// tb_cnn_fmap_buffer: directed table-driven bench for the frame buffer
module tb_cnn_fmap_buffer;

    localparam int CO = 2, I_BW = 23, O_BW = 8, W = 4, H = 3, SBW = 5;
    localparam int FR = W * H, N = CO * FR;

    logic clk = 1'b0, reset = 1'b1, i_start = 1'b0, i_relu_en = 1'b0;
    logic i_valid = 1'b0, i_rd_ready = 1'b0;
    logic [SBW-1:0] i_shift = '0;
    logic [CO*I_BW-1:0] i_fmap = '0;
    logic o_busy, o_frame_done, o_err_overrun, o_rd_valid, o_rd_last;
    logic [O_BW-1:0] o_rd_data;
    logic [0:0] o_rd_ch;
    logic [1:0] o_rd_x, o_rd_y;

    typedef struct {int a; int b; int ea; int eb;} vec_t;
    vec_t tab[4][FR];
    int fsh[4] = '{0, 4, 4, 31};
    bit frl[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int f1a[FR] = '{1000, -1000, 5000, -5000, 0, 15, 16, -1, -16, -17, 2047, 2048};
    int f1ea[FR] = '{62, -63, 127, -128, 0, 0, 1, -1, -1, -2, 127, 127};
    int f1eb[FR] = '{-63, 62, -128, 127, 0, -1, -1, 0, 1, 1, -128, -128};
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    cnn_fmap_buffer #(.CO(CO), .I_BW(I_BW), .O_BW(O_BW), .OUT_W(W), .OUT_H(H), .SHIFT_BW(SBW)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_shift(i_shift), .i_relu_en(i_relu_en),
        .i_valid(i_valid), .i_fmap(i_fmap), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_err_overrun(o_err_overrun), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
        .o_rd_data(o_rd_data), .o_rd_ch(o_rd_ch), .o_rd_x(o_rd_x), .o_rd_y(o_rd_y),
        .o_rd_last(o_rd_last)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic start(input int f);
        @(posedge clk); #1;
        i_start = 1'b1; i_shift = SBW'(fsh[f]); i_relu_en = frl[f];
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic feed(input int f, input int nb);
        for (int k = 0; k < nb; k++) begin
            @(posedge clk); #1;
            i_valid = 1'b1;
            i_fmap = {I_BW'(tab[f][k].b), I_BW'(tab[f][k].a)};
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic readout(input int f, input bit rnd, input bit lat, input bit opulse, input int nxt);
        int i = 0, saved = 0, ech, ed;
        bit stall = 0, done = 0, exp_done = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (lat && cyc < 2) chk("first_valid_latency", int'(o_rd_valid), cyc);
            if (stall) chk("stall_hold", int'({o_rd_valid, o_rd_data, o_rd_ch, o_rd_x, o_rd_y, o_rd_last}), saved);
            i_valid = opulse && cyc == 8;
            if (i_valid) i_fmap = (CO*I_BW)'({$urandom(), $urandom()});
            if (o_frame_done || exp_done) begin
                chk("frame_done_pulse", int'(o_frame_done), int'(exp_done));
                chk("busy_low_at_done", int'(o_busy), 0);
                chk("beat_count", i, N);
                if (opulse) chk("overrun_sticky_readout", int'(o_err_overrun), 1);
                done = 1;
                if (nxt >= 0) begin
                    i_start = 1'b1; i_shift = SBW'(fsh[nxt]); i_relu_en = frl[nxt];
                end
            end else begin
                exp_done = 0;
                i_rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (o_rd_valid && i_rd_ready) begin
                    if (i < N) begin
                        ech = i / FR;
                        ed = ech != 0 ? tab[f][i % FR].eb : tab[f][i % FR].ea;
                        chk("beat_data", int'($signed(o_rd_data)), ed);
                        chk("beat_coord", int'({o_rd_ch, o_rd_y, o_rd_x}), (ech << 4) | (((i % FR) / W) << 2) | (i % W));
                        chk("beat_last", int'(o_rd_last), int'(i == N - 1));
                    end else chk("extra_beat", i, N - 1);
                    exp_done = o_rd_last;
                    i++;
                end
                stall = o_rd_valid && !i_rd_ready;
                saved = int'({o_rd_valid, o_rd_data, o_rd_ch, o_rd_x, o_rd_y, o_rd_last});
            end
        end
        if (!done) chk("readout_timeout", 0, 1);
        if (done && nxt >= 0) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            @(negedge clk);
            chk("busy_after_coincident_start", int'(o_busy), 1);
            chk("overrun_cleared_by_start", int'(o_err_overrun), 0);
        end
    endtask

    initial begin
        int nd;
        for (int k = 0; k < FR; k++) begin
            tab[0][k] = '{k, -k, k, -k};
            tab[1][k] = '{f1a[k], -f1a[k], f1ea[k], f1eb[k]};
            tab[2][k] = '{-1000 * (k + 1), 16 * k + 5, 0, k};
            tab[3][k] = '{4194303 - k, -4194304 + k, 0, -1};
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({o_busy, o_frame_done, o_err_overrun, o_rd_valid, o_rd_data,
                                   o_rd_ch, o_rd_x, o_rd_y, o_rd_last}), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        start(0);
        @(negedge clk);
        chk("busy_after_start", int'(o_busy), 1);
        feed(0, FR);
        readout(0, 0, 1, 0, -1);
        chk("no_overrun_clean", int'(o_err_overrun), 0);

        start(1);
        feed(1, FR);
        readout(1, 1, 0, 0, -1);

        @(posedge clk); #1;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        chk("overrun_set_idle", int'(o_err_overrun), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("overrun_stays_set", int'(o_err_overrun), 1);
        start(2);
        @(negedge clk);
        chk("overrun_cleared_start", int'(o_err_overrun), 0);
        feed(2, FR);
        readout(2, 0, 0, 1, 3);
        feed(3, FR);
        readout(3, 1, 0, 0, -1);

        start(0);
        feed(0, 5);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy_low", int'(o_busy), 0);
        chk("abort_no_done", int'(o_frame_done), 0);
        start(0);
        feed(0, FR);
        readout(0, 1, 1, 0, -1);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            nd += int'(o_frame_done);
        end
        chk("single_done", nd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
